// File: rtl/jk_drive_serializer_if.sv
// Word handshake between a producer and the JK drive serializer.
interface jk_drive_serializer_if #(parameter int WIDTH = 8);
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;

  modport master (output din, output din_valid, input din_ready);
  modport slave  (input din, input din_valid, output din_ready);
endinterface

// File: rtl/jk_drive_serializer.sv
// Serializes words MSB first onto an external JK flip-flop via J/K excitation,
// tracking the expected flop state and flagging feedback mismatches.
module jk_drive_serializer #(
  parameter int WIDTH     = 8,
  parameter bit TOGGLE_EN = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  jk_drive_serializer_if.slave  bus,
  output logic                  j,
  output logic                  k,
  input  logic                  qn,
  input  logic                  qn_bar,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, CHECK} state_t;

  state_t           state;
  logic [WIDTH-1:0] sreg;
  logic [CNT_W-1:0] cnt;
  logic             q_model;
  logic             chk_en;
  logic             mismatch;

  // Excitation that moves the flop from q to b; never 1/1 in set/reset mode.
  function automatic logic [1:0] excite(input logic b, input logic q);
    if (b == q)
      return 2'b00;
    if (TOGGLE_EN)
      return 2'b11;
    return b ? 2'b10 : 2'b01;
  endfunction

  assign bus.din_ready = (state == IDLE) && !rst;
  assign busy          = (state != IDLE);

  always_comb begin
    {j, k} = 2'b00;
    if (state == SHIFT)
      {j, k} = excite(sreg[WIDTH-1], q_model);
  end

  // The first SHIFT cycle has no prior bit driven yet, so it is not checked.
  assign chk_en   = ((state == SHIFT) && (cnt != '0)) || (state == CHECK);
  assign mismatch = chk_en && ((qn != q_model) || (qn == qn_bar));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      sreg    <= '0;
      cnt     <= '0;
      q_model <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      err  <= err | mismatch;
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.din_valid) begin
            sreg  <= bus.din;
            cnt   <= '0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          q_model <= sreg[WIDTH-1];
          sreg    <= sreg << 1;
          cnt     <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(WIDTH - 1)) begin
            state <= CHECK;
            done  <= 1'b1;
          end
        end
        CHECK: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jk_drive_serializer.sv
// Scoreboard bench: one set/reset-mode and one toggle-mode serializer, each
// driving a behavioral JK flop whose Q is fed back.
module tb_jk_drive_serializer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {logic j; logic k; logic done;} exp_t;
  exp_t q0[$];
  exp_t q1[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_done[2] = '{-1000, -1000};
  int done_gap[2]  = '{0, 0};
  int acc_cyc[2]   = '{0, 0};

  jk_drive_serializer_if #(.WIDTH(8)) bus0 ();
  jk_drive_serializer_if #(.WIDTH(8)) bus1 ();

  logic j0, k0, busy0, done0, err0, qn0, qnb0, fq0;
  logic j1, k1, busy1, done1, err1, qn1, qnb1, fq1;
  logic ov_en0 = 1'b0, ov_qn0 = 1'b0, ov_qnb0 = 1'b0;

  jk_drive_serializer #(.WIDTH(8), .TOGGLE_EN(1'b0)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0), .j(j0), .k(k0), .qn(qn0), .qn_bar(qnb0),
    .busy(busy0), .done(done0), .err(err0));

  jk_drive_serializer #(.WIDTH(8), .TOGGLE_EN(1'b1)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1), .j(j1), .k(k1), .qn(qn1), .qn_bar(qnb1),
    .busy(busy1), .done(done1), .err(err1));

  // Behavioral JK flops sharing the serializer reset
  always @(posedge clk or posedge rst) begin
    if (rst) fq0 <= 1'b0;
    else case ({j0, k0})
      2'b10: fq0 <= 1'b1;
      2'b01: fq0 <= 1'b0;
      2'b11: fq0 <= ~fq0;
      default: fq0 <= fq0;
    endcase
  end
  always @(posedge clk or posedge rst) begin
    if (rst) fq1 <= 1'b0;
    else case ({j1, k1})
      2'b10: fq1 <= 1'b1;
      2'b01: fq1 <= 1'b0;
      2'b11: fq1 <= ~fq1;
      default: fq1 <= fq1;
    endcase
  end

  assign qn0  = ov_en0 ? ov_qn0  : fq0;
  assign qnb0 = ov_en0 ? ov_qnb0 : ~fq0;
  assign qn1  = fq1;
  assign qnb1 = ~fq1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", name, got, want);
    end
  endtask

  task automatic mon(input int d, input logic jv, input logic kv, input logic dv,
                     input logic bv, input logic rv);
    exp_t e;
    if (bv) begin
      checks++;
      if (rv !== 1'b0) begin
        failures++;
        $display("FAIL ready_while_busy dut%0d got=%b expected=0", d, rv);
      end
      checks++;
      if ((d == 0 ? q0.size() : q1.size()) == 0) begin
        failures++;
        $display("FAIL unexpected_word dut%0d got={j,k,done}=%b expected=idle", d, {jv, kv, dv});
      end else begin
        e = (d == 0) ? q0.pop_front() : q1.pop_front();
        if ({jv, kv, dv} !== e) begin
          failures++;
          $display("FAIL jk_done dut%0d got={j,k,done}=%b expected=%b", d, {jv, kv, dv}, e);
        end
      end
      if (dv === 1'b1) begin
        done_gap[d]  = cyc - last_done[d];
        last_done[d] = cyc;
      end
    end else begin
      checks++;
      if ({jv, kv, dv} !== 3'b000) begin
        failures++;
        $display("FAIL idle_outputs dut%0d got={j,k,done}=%b expected=000", d, {jv, kv, dv});
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, j0, k0, done0, busy0, bus0.din_ready);
    mon(1, j1, k1, done1, busy1, bus1.din_ready);
  end

  task automatic push_word(input int d, input logic [15:0] jk);
    exp_t e;
    for (int i = 7; i >= 0; i--) begin
      e = {jk[2*i+1], jk[2*i], 1'b0};
      if (d == 0) q0.push_back(e); else q1.push_back(e);
    end
    e = 3'b001;
    if (d == 0) q0.push_back(e); else q1.push_back(e);
  endtask

  // jk holds the hand-computed {j,k} pairs for bits 7..0
  task automatic send(input int d, input logic [7:0] w, input logic [15:0] jk, input bit keep);
    logic rdy;
    int n;
    @(negedge clk);
    if (d == 0) begin bus0.din = w; bus0.din_valid = 1'b1; end
    else        begin bus1.din = w; bus1.din_valid = 1'b1; end
    n = 0;
    rdy = (d == 0) ? bus0.din_ready : bus1.din_ready;
    while (!rdy && n < 40) begin
      @(negedge clk);
      n++;
      rdy = (d == 0) ? bus0.din_ready : bus1.din_ready;
    end
    if (!rdy) begin
      checks++; failures++;
      $display("FAIL ready_timeout dut%0d got=0 expected=1", d);
      bus0.din_valid = 1'b0; bus1.din_valid = 1'b0;
      return;
    end
    acc_cyc[d] = cyc;
    push_word(d, jk);
    @(posedge clk);
    #1;
    if (!keep) begin
      if (d == 0) bus0.din_valid = 1'b0; else bus1.din_valid = 1'b0;
    end
  endtask

  task automatic wait_done(input int d);
    logic seen;
    seen = 1'b0;
    for (int n = 0; n < 60 && !seen; n++) begin
      @(negedge clk);
      seen = (d == 0) ? done0 : done1;
    end
    #1;
    if (!seen) begin
      checks++; failures++;
      $display("FAIL done_timeout dut%0d got=0 expected=1", d);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    q0.delete(); q1.delete();
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
  endtask

  localparam logic [15:0] JK_B2   = 16'b10_01_10_00_01_00_10_01;
  localparam logic [15:0] JK_55_0 = 16'b00_10_01_10_01_10_01_10;
  localparam logic [15:0] JK_55_1 = 16'b01_10_01_10_01_10_01_10;
  localparam logic [15:0] JK_80   = 16'b10_01_00_00_00_00_00_00;
  localparam logic [15:0] JK_A5   = 16'b10_01_10_01_00_10_01_10;
  localparam logic [15:0] JK_T7   = 16'b11_00_00_00_00_00_00_00;

  initial begin
    bus0.din = '0; bus0.din_valid = 1'b0;
    bus1.din = '0; bus1.din_valid = 1'b0;
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_j", j0, 0);        chk("rst_k", k0, 0);
    chk("rst_ready", bus0.din_ready, 0);
    chk("rst_busy", busy0, 0);  chk("rst_done", done0, 0);
    chk("rst_err", err0, 0);    chk("rst_ready1", bus1.din_ready, 0);
    #2 rst = 1'b0;
    @(posedge clk); #1;
    chk("ready_after_rst", bus0.din_ready, 1);

    // Toggle mode: FF then 00 back-to-back
    send(1, 8'hFF, JK_T7, 1'b1);
    send(1, 8'h00, JK_T7, 1'b0);
    wait_done(1);
    chk("toggle_done_gap", done_gap[1], 10);
    chk("toggle_err", err1, 0);

    // Set/reset mode: B2 from reset
    send(0, 8'hB2, JK_B2, 1'b0);
    wait_done(0);
    chk("b2_latency", last_done[0] - acc_cyc[0], 9);
    chk("b2_err", err0, 0);
    chk("b2_final_q", fq0, 0);

    // din_valid held high with 55
    send(0, 8'h55, JK_55_0, 1'b1);
    send(0, 8'h55, JK_55_1, 1'b0);
    wait_done(0);
    chk("hold_done_gap", done_gap[0], 10);
    chk("hold_err", err0, 0);

    // qn stuck at 0 while sending 80
    do_reset();
    ov_en0 = 1'b1; ov_qn0 = 1'b0; ov_qnb0 = 1'b1;
    send(0, 8'h80, JK_80, 1'b0);
    @(negedge clk); chk("stuck_err_bit0", err0, 0);
    @(negedge clk); chk("stuck_err_bit1", err0, 0);
    @(negedge clk); chk("stuck_err_set", err0, 1);
    wait_done(0);
    chk("stuck_err_at_done", err0, 1);
    ov_en0 = 1'b0;
    send(0, 8'hB2, JK_B2, 1'b0);
    wait_done(0);
    chk("stuck_err_sticky", err0, 1);
    do_reset();
    chk("stuck_err_cleared", err0, 0);

    // Abort mid-word, then A5 from q_model=0
    send(0, 8'hB2, JK_B2, 1'b0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    q0.delete(); q1.delete();
    #1;
    chk("abort_j", j0, 0); chk("abort_k", k0, 0);
    chk("abort_busy", busy0, 0); chk("abort_done", done0, 0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    send(0, 8'hA5, JK_A5, 1'b0);
    wait_done(0);
    chk("a5_err", err0, 0);
    chk("a5_final_q", fq0, 1);

    // qn == qn_bar glitch for one SHIFT cycle
    do_reset();
    send(0, 8'hB2, JK_B2, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("glitch_err_before", err0, 0);
    ov_en0 = 1'b1; ov_qn0 = 1'b1; ov_qnb0 = 1'b1;
    @(negedge clk);
    ov_en0 = 1'b0;
    wait_done(0);
    chk("glitch_err_set", err0, 1);

    repeat (3) @(negedge clk);
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
